// File: rtl/seq_detector.sv
// ---------------------------------------------------------------------------
// seq_detector
//   Serial pattern detector. Valid bits are shifted into a PAT_W-bit window;
//   once the window holds PAT_W bits equal to PATTERN a registered one-cycle
//   hit pulse is raised and a saturating match counter advances.
//
// Parameters
//   PAT_W    pattern length in bits (2..32)
//   PATTERN  target sequence, MSB is the earliest bit received
//   OVERLAP  1: a suffix of a match may start the next match
//            0: window and fill restart after each match
//   CNT_W    match counter width (1..32)
//
// Ports
//   clk_i    system clock, rising edge
//   reset_i  synchronous active-high reset
//   valid_i  in_i is sampled on this edge only when high
//   in_i     serial data bit
//   clr_i    synchronous clear of count_o only
//   hit_o    one-cycle match pulse (registered)
//   state_o  status: 00 IDLE, 01 FILL, 10 ARMED, 11 MATCH
//   count_o  saturating number of matches (registered)
// ---------------------------------------------------------------------------
module seq_detector #(
    parameter int unsigned             PAT_W   = 4,
    parameter logic [PAT_W-1:0]        PATTERN = PAT_W'(4'b1011),
    parameter bit                      OVERLAP = 1'b1,
    parameter int unsigned             CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic             in_i,
    input  logic             clr_i,
    output logic             hit_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] count_o
);

    // Elaboration-time parameter checks
    if (PAT_W < 2 || PAT_W > 32) begin : g_bad_pat_w
        $error("seq_detector: PAT_W must be in 2..32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("seq_detector: CNT_W must be in 1..32");
    end

    localparam int unsigned     FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]   FULL = FW'(PAT_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_ARMED = 2'b10,
        ST_MATCH = 2'b11
    } state_e;

    logic [PAT_W-1:0] window_q, window_d;
    logic [FW-1:0]    fill_q,   fill_d;
    logic             hit_q,    hit_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic [PAT_W-1:0] win_upd;
    logic [FW-1:0]    fill_upd;
    logic             match;
    state_e           state;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            window_q <= '0;
            fill_q   <= '0;
            hit_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
            hit_q    <= hit_d;
            count_q  <= count_d;
        end
    end

    // Next-state logic
    always_comb begin
        win_upd  = {window_q[PAT_W-2:0], in_i};
        fill_upd = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        match    = valid_i && (fill_upd == FULL) && (win_upd == PATTERN);

        window_d = window_q;
        fill_d   = fill_q;
        if (valid_i) begin
            window_d = win_upd;
            fill_d   = fill_upd;
        end
        if (match && !OVERLAP) begin
            window_d = '0;
            fill_d   = '0;
        end

        hit_d = match;

        // Clear wins over a simultaneous match; counter sticks at all-ones
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (match && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Output decode from registered values only
    always_comb begin
        if (hit_q) begin
            state = ST_MATCH;
        end else if (fill_q == '0) begin
            state = ST_IDLE;
        end else if (fill_q < FULL) begin
            state = ST_FILL;
        end else begin
            state = ST_ARMED;
        end
    end

    assign state_o = state;
    assign hit_o   = hit_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_seq_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_detector
//   Four detector configurations driven by one shared stimulus stream. A
//   reference model keeps each configuration's received bits as a queue and
//   derives hit/state/count from that history; expectations are queued per
//   edge and a monitor compares them one cycle later.
// ---------------------------------------------------------------------------
module tb_seq_detector;

    localparam int NC = 4;
    localparam int PW [NC] = '{4, 4, 4, 6};
    localparam int PT [NC] = '{'b1011, 'b1011, 'b1011, 'b100110};
    localparam int OV [NC] = '{1, 0, 1, 1};
    localparam int CW [NC] = '{8, 8, 2, 4};

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic valid_i = 1'b0;
    logic in_i    = 1'b0;
    logic clr_i   = 1'b0;

    logic       hit0, hit1, hit2, hit3;
    logic [1:0] st0, st1, st2, st3;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [3:0] cnt3;

    always #5 clk = ~clk;

    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .in_i(in_i), .clr_i(clr_i),
        .hit_o(hit0), .state_o(st0), .count_o(cnt0));

    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .in_i(in_i), .clr_i(clr_i),
        .hit_o(hit1), .state_o(st1), .count_o(cnt1));

    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .in_i(in_i), .clr_i(clr_i),
        .hit_o(hit2), .state_o(st2), .count_o(cnt2));

    seq_detector #(.PAT_W(6), .PATTERN(6'b100110), .OVERLAP(1'b1), .CNT_W(4)) u_w6 (
        .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .in_i(in_i), .clr_i(clr_i),
        .hit_o(hit3), .state_o(st3), .count_o(cnt3));

    typedef struct packed {
        logic [NC-1:0]       hit;
        logic [NC-1:0][1:0]  st;
        logic [NC-1:0][31:0] cnt;
    } exp_t;

    exp_t sbq [$];
    bit   hist [NC][$];
    int unsigned mcnt [NC];

    int checks = 0;
    int errors = 0;

    // Reference model for one edge: history of accepted bits per config
    task automatic model_edge(input bit r, input bit v, input bit b, input bit c);
        exp_t e;
        e = '0;
        for (int k = 0; k < NC; k++) begin
            bit m;
            int unsigned val;
            int unsigned sz;
            m = 1'b0;
            if (r) begin
                hist[k].delete();
                mcnt[k] = 0;
            end else begin
                if (v) begin
                    hist[k].push_back(b);
                    if (hist[k].size() > PW[k]) void'(hist[k].pop_front());
                    if (hist[k].size() == PW[k]) begin
                        val = 0;
                        for (int j = 0; j < PW[k]; j++) val = val * 2 + hist[k][j];
                        m = (val == PT[k]);
                    end
                    if (m && OV[k] == 0) hist[k].delete();
                end
                if (c) mcnt[k] = 0;
                else if (m && mcnt[k] < (32'd1 << CW[k]) - 1) mcnt[k]++;
            end
            sz = hist[k].size();
            e.hit[k] = m;
            e.st[k]  = m ? 2'd3 : (sz == 0) ? 2'd0 : (sz < PW[k]) ? 2'd1 : 2'd2;
            e.cnt[k] = mcnt[k];
        end
        sbq.push_back(e);
    endtask

    task automatic step(input bit r, input bit v, input bit b, input bit c);
        reset_i = r;
        valid_i = v;
        in_i    = b;
        clr_i   = c;
        model_edge(r, v, b, c);
        @(negedge clk);
    endtask

    task automatic bits(input int n, input logic [31:0] seq);
        for (int i = n - 1; i >= 0; i--) begin
            logic [31:0] s;
            s = seq;
            step(1'b0, 1'b1, s[i], 1'b0);
        end
    endtask

    // Monitor: one expectation per edge, sampled just after the edge
    always @(posedge clk) begin
        #1;
        if (sbq.size() > 0) begin
            exp_t e;
            logic [NC-1:0]       ah;
            logic [NC-1:0][1:0]  as;
            logic [NC-1:0][31:0] ac;
            e  = sbq.pop_front();
            ah = {hit3, hit2, hit1, hit0};
            as = {st3, st2, st1, st0};
            ac = {{28'd0, cnt3}, {30'd0, cnt2}, {24'd0, cnt1}, {24'd0, cnt0}};
            for (int k = 0; k < NC; k++) begin
                checks++;
                if (ah[k] !== e.hit[k]) begin
                    errors++;
                    $display("FAIL hit cfg%0d t=%0t: got %b expected %b", k, $time, ah[k], e.hit[k]);
                end
                checks++;
                if (as[k] !== e.st[k]) begin
                    errors++;
                    $display("FAIL state cfg%0d t=%0t: got %b expected %b", k, $time, as[k], e.st[k]);
                end
                checks++;
                if (ac[k] !== e.cnt[k]) begin
                    errors++;
                    $display("FAIL count cfg%0d t=%0t: got %0d expected %0d", k, $time, ac[k], e.cnt[k]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        // Reset with valid low
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Single match, then hold one idle cycle
        bits(4, 32'b1011);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Overlap stream
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits(7, 32'b1011011);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Bubbles inside a partial match
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits(2, 32'b10);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
        bits(2, 32'b11);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation: five matches, then clear coinciding with a match
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) bits(4, 32'b1011);
        bits(3, 32'b101);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset discards a partial match
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits(3, 32'b101);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        bits(1, 32'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        bits(4, 32'b1011);

        // Longer pattern directed hit
        step(1'b1, 1'b0, 1'b0, 1'b0);
        bits(9, 32'b100110110);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 75,
                 1'($urandom),
                 $urandom_range(0, 99) < 3);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits; legal range 2..32.
REQ-002 Parameter PATTERN, default 4'b1011: PAT_W-bit target sequence; MSB is the earliest bit received.
REQ-003 Parameter OVERLAP, default 1: 1 = overlapping matches allowed; 0 = window restarts after each match.
REQ-004 Parameter CNT_W, default 8: width of the match counter; legal range 1..32.
REQ-005 clk_i  in  1  system clock; all state changes on its rising edge.
REQ-006 reset_i  in  1  reset, synchronous and active-high.
REQ-007 valid_i  in  1  in_i is sampled on this edge only when valid_i=1.
REQ-008 in_i  in  1  serial data bit.
REQ-009 clr_i  in  1  synchronous clear of count_o only.
REQ-010 hit_o  out  1  one-cycle match pulse, registered.
REQ-011 state_o  out  2  status: 00 IDLE, 01 FILL, 10 ARMED, 11 MATCH.
REQ-012 count_o  out  CNT_W  saturating count of matches, registered.

Function
REQ-013 The block SHALL hold a PAT_W-bit shift window and a fill counter (0..PAT_W).
REQ-014 On an edge with valid_i=1, window SHALL become {window[PAT_W-2:0], in_i} and fill SHALL become min(fill+1, PAT_W).
REQ-015 A match SHALL occur on that edge when the updated fill equals PAT_W and the updated window equals PATTERN.
REQ-016 hit_o SHALL be 1 in the cycle after the edge that sampled the completing bit (latency 1), and 0 in every other cycle.
REQ-017 With OVERLAP=0, a match SHALL set fill to 0 and window to 0 on the same edge.
REQ-018 With OVERLAP=1, a match SHALL leave window and fill as updated, so a suffix of the match can begin the next match.
REQ-019 With valid_i=0, window and fill SHALL hold and hit_o SHALL be 0; bubbles SHALL NOT break a partial match.
REQ-020 state_o SHALL be decoded from registered values, in priority order: MATCH if hit_o=1; else IDLE if fill=0; else FILL if fill<PAT_W; else ARMED.
REQ-021 On each match, count_o SHALL increment by 1 and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-022 clr_i=1 SHALL set count_o to 0 on that edge; this takes priority over a simultaneous match, which is not counted.
REQ-023 clr_i SHALL NOT affect window, fill, hit_o or state_o; a simultaneous match still pulses hit_o.
REQ-024 Out-of-range parameters SHALL fail elaboration.

Reset
REQ-025 While reset_i=1 at an edge, window, fill, hit_o and count_o SHALL all become 0, so state_o=00.
REQ-026 Reset SHALL take priority over valid_i, in_i and clr_i.
REQ-027 A partial match in progress when reset is asserted SHALL be discarded.
REQ-028 Outputs SHALL be defined from the first edge with reset_i=1.

Verification
REQ-029 Reset 2 cycles, valid_i=0 -> hit_o=0, state_o=00, count_o=0.
REQ-030 Defaults; valid bits 1,0,1,1 -> hit_o=1 for exactly one cycle after the 4th bit; state_o 01,01,01,11 then 10; count_o=1.
REQ-031 Stream 1,0,1,1,0,1,1:
  - OVERLAP=1 -> hits after bits 4 and 7; count_o=2.
  - OVERLAP=0 -> hit after bit 4 only; count_o=1; final state_o=01.
REQ-032 Bits 1,0 then 3 cycles valid_i=0 then 1,1 -> one hit, one cycle after the last valid bit.
REQ-033 CNT_W=2, 5 matches -> count_o stays at 3. Then clr_i=1 on the same edge as a match -> count_o=0 and hit_o=1.
REQ-034 Bits 1,0,1, reset 1 cycle, then bit 1 -> no hit; state_o=01 with fill=1; the full 1,0,1,1 is then required for a hit.
